// File: rtl/mux_sel_seq.sv
// Select sequencer for the upstream 2:1 mux: auto alternation or req/ack switching,
// with a one-cycle break-before-make gap and a saturating switch counter.
module mux_sel_seq #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               auto,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               req,
  input  logic               req_sel,
  output logic               sel,
  output logic               sel_valid,
  output logic               busy,
  output logic               ack,
  output logic [7:0]         toggles
);

  typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

  state_t             state, state_next;
  logic [DWELL_W-1:0] cnt, cnt_next;
  logic               target, target_next;
  logic               pending, pending_next;
  logic               sel_next, ack_next;
  logic [7:0]         toggles_next;
  logic               dwell_hit;

  // Greater-or-equal so that lowering dwell below the running count never stalls.
  assign dwell_hit = ({1'b0, cnt} + 1'b1) >= {1'b0, dwell};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      target    <= 1'b0;
      pending   <= 1'b0;
      sel       <= 1'b0;
      sel_valid <= 1'b0;
      busy      <= 1'b0;
      ack       <= 1'b0;
      toggles   <= 8'd0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      target    <= target_next;
      pending   <= pending_next;
      sel       <= sel_next;
      sel_valid <= (state_next == RUN);
      busy      <= (state_next == GAP);
      ack       <= ack_next;
      toggles   <= toggles_next;
    end
  end

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    target_next  = target;
    pending_next = pending;
    sel_next     = sel;
    ack_next     = 1'b0;
    toggles_next = toggles;
    case (state)
      IDLE: begin
        if (en) begin
          state_next = RUN;
          cnt_next   = '0;
        end
      end
      RUN: begin
        if (!en) begin
          state_next = IDLE;
        end else if (auto && (dwell != '0)) begin
          if (dwell_hit) begin
            state_next   = GAP;
            target_next  = ~sel;
            pending_next = 1'b0;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end else if (!auto && req) begin
          if (req_sel != sel) begin
            state_next   = GAP;
            target_next  = req_sel;
            pending_next = 1'b1;
          end else begin
            ack_next = 1'b1;
          end
        end
      end
      GAP: begin
        // The switch completes even if en dropped during the gap.
        sel_next     = target;
        toggles_next = (toggles == 8'd255) ? toggles : toggles + 8'd1;
        cnt_next     = '0;
        ack_next     = pending;
        pending_next = 1'b0;
        state_next   = en ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mux_sel_seq.sv
// Directed bench for mux_sel_seq; expected output vectors go through a scoreboard queue.
module tb_mux_sel_seq;

  logic       clk = 1'b0;
  logic       reset, en, auto, req, req_sel;
  logic [3:0] dwell;
  logic       sel, sel_valid, busy, ack;
  logic [7:0] toggles;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string     tag;
    logic [11:0] vec;
  } exp_t;
  exp_t sb[$];

  mux_sel_seq #(.DWELL_W(4)) dut (
    .clk(clk), .reset(reset), .en(en), .auto(auto), .dwell(dwell),
    .req(req), .req_sel(req_sel), .sel(sel), .sel_valid(sel_valid),
    .busy(busy), .ack(ack), .toggles(toggles)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] mk(input logic s, input logic v, input logic b,
                                     input logic a, input int t);
    logic [7:0] t8;
    t8 = t[7:0];
    return {s, v, b, a, t8};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic compare_head();
    exp_t e;
    logic [11:0] obs;
    e = sb.pop_front();
    obs = {sel, sel_valid, busy, ack, toggles};
    checks++;
    assert (obs === e.vec) else begin
      errors++;
      $error("FAIL %s observed sel/val/busy/ack/tog=%b/%b/%b/%b/%0d expected %b/%b/%b/%b/%0d",
             e.tag, obs[11], obs[10], obs[9], obs[8], obs[7:0],
             e.vec[11], e.vec[10], e.vec[9], e.vec[8], e.vec[7:0]);
    end
  endtask

  // Push the expectation for the next edge, advance, then pop and check it.
  task automatic step(input string tag, input logic [11:0] vec);
    exp_t e;
    e.tag = tag;
    e.vec = vec;
    sb.push_back(e);
    tick();
    compare_head();
  endtask

  // Asynchronous check: no clock edge between push and compare.
  task automatic now_check(input string tag, input logic [11:0] vec);
    exp_t e;
    e.tag = tag;
    e.vec = vec;
    sb.push_back(e);
    compare_head();
  endtask

  task automatic check_tog(input string tag, input int t);
    checks++;
    assert (toggles === t[7:0]) else begin
      errors++;
      $error("FAIL %s observed toggles=%0d expected %0d", tag, toggles, t);
    end
  endtask

  initial begin
    int found;
    reset = 1'b1; en = 1'b0; auto = 1'b0; req = 1'b0; req_sel = 1'b0; dwell = 4'd0;
    step("reset_state", mk(0, 0, 0, 0, 0));
    reset = 1'b0;
    step("idle_no_en", mk(0, 0, 0, 0, 0));

    // Auto alternation, dwell=3: 3 valid cycles then 1 gap per channel.
    en = 1'b1; auto = 1'b1; dwell = 4'd3;
    for (int i = 1; i <= 17; i++) begin
      int p;
      p = (i - 1) % 4;
      step($sformatf("auto_d3_c%0d", i),
           mk(((i - 1) / 4) % 2, p < 3, p == 3, 0, (i - 1) / 4));
    end

    // Manual request with differing select: gap then sel=1 with ack.
    auto = 1'b0; req = 1'b1; req_sel = 1'b1;
    step("req_gap", mk(0, 0, 1, 0, 4));
    req = 1'b0;
    step("req_done_ack", mk(1, 1, 0, 1, 5));
    step("req_ack_drop", mk(1, 1, 0, 0, 5));

    // Equal-select request: ack next cycle, no gap.
    req = 1'b1; req_sel = 1'b1;
    step("req_eq_ack", mk(1, 1, 0, 1, 5));
    req = 1'b0;
    step("req_eq_drop", mk(1, 1, 0, 0, 5));

    // Drop en during the gap: switch still completes, then IDLE.
    req = 1'b1; req_sel = 1'b0;
    step("dis_gap", mk(1, 0, 1, 0, 5));
    req = 1'b0; en = 1'b0;
    step("dis_complete", mk(0, 0, 0, 1, 6));
    step("dis_idle", mk(0, 0, 0, 0, 6));
    en = 1'b1;
    step("reenable", mk(0, 1, 0, 0, 6));

    // dwell=0 in auto mode: no switching, req ignored.
    auto = 1'b1; dwell = 4'd0; req = 1'b1; req_sel = 1'b1;
    for (int i = 0; i < 4; i++) step($sformatf("dwell0_c%0d", i), mk(0, 1, 0, 0, 6));
    req = 1'b0;

    // dwell=1: switch every 2 cycles.
    dwell = 4'd1;
    step("d1_gap0", mk(0, 0, 1, 0, 6));
    step("d1_run1", mk(1, 1, 0, 0, 7));
    step("d1_gap1", mk(1, 0, 1, 0, 7));
    step("d1_run0", mk(0, 1, 0, 0, 8));

    // Saturation: well over 247 more switches.
    for (int i = 0; i < 540; i++) tick();
    check_tog("sat_255", 255);
    tick(); tick(); tick();
    check_tog("sat_hold", 255);

    // Reset inside a gap aborts the switch immediately.
    found = 0;
    for (int i = 0; i < 4 && found == 0; i++) begin
      if (busy) found = 1;
      else tick();
    end
    checks++;
    assert (found == 1) else begin
      errors++;
      $error("FAIL gap_wait observed no gap within 4 cycles expected busy=1");
    end
    reset = 1'b1;
    #1;
    now_check("reset_in_gap", mk(0, 0, 0, 0, 0));
    reset = 1'b0;
    step("enable_after_reset", mk(0, 1, 0, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_sel_seq.md
# mux_sel_seq

Select sequencer that drives the select line of the 2:1 multiplexer stage (`mux2a1`) directly upstream of it. It chooses which of the two data inputs (D0/D1) the mux passes, either alternating automatically after a programmable dwell time or on a request/acknowledge handshake. Every channel change is break-before-make: a one-cycle gap with `sel_valid` low, so downstream logic never samples Y while S is changing. A saturating counter records the number of completed switches.

## Interface
- `DWELL_W`, 4, width of the dwell count.
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous, active-high reset.
- `en`  input  1  sequencer enable.
- `auto`  input  1  1 = automatic alternation, 0 = request-driven.
- `dwell`  input  DWELL_W  cycles `sel_valid` stays high per channel in auto mode; 0 disables auto switching.
- `req`  input  1  switch request, sampled in RUN when `auto`=0.
- `req_sel`  input  1  requested select value.
- `sel`  output  1  drives mux S (0 → D0, 1 → D1).
- `sel_valid`  output  1  mux output Y is stable and usable.
- `busy`  output  1  high during the GAP cycle.
- `ack`  output  1  one-cycle request-completion pulse.
- `toggles`  output  8  completed switch count, saturates at 255.

## Operation
- Reset is asynchronous and active-high. While `reset`=1: state=IDLE, `sel`=0, `sel_valid`=0, `busy`=0, `ack`=0, `toggles`=0, internal `cnt`=0, target=0.
- All outputs are registered. Each of the following is a state-to-state transition on a clock edge.
- IDLE: `sel_valid`=0 and `sel` holds its value. `en`=1 → RUN, with `cnt`=0.
- RUN: `sel_valid`=1. Priority order:
  1. `en`=0 → IDLE.
  2. `auto`=1 and `dwell`≠0:
     - `cnt`==`dwell`−1 → GAP, with target=~`sel`.
     - Otherwise `cnt`++.
     - `req` is ignored and produces no `ack`.
  3. `auto`=0 and `req`=1:
     - `req_sel`≠`sel` → GAP, with target=`req_sel` and the request marked pending.
     - `req_sel`==`sel` → `ack`=1 on the next cycle and stay in RUN.
  4. Otherwise hold. `cnt` is frozen when `auto`=0 or `dwell`=0.
- GAP (exactly one cycle): `sel_valid`=0, `busy`=1. On the next edge:
  - `sel`←target.
  - `toggles`←min(`toggles`+1, 255).
  - `cnt`←0.
  - `ack`=1 if the request was pending.
  - Next state is RUN if `en`=1, else IDLE. The switch still completes when `en` drops during GAP.
- A change of `dwell` or `auto` takes effect at the next RUN evaluation. Lowering `dwell` below `cnt`+1 does not stall the sequencer: it switches when `cnt`≥`dwell`−1.
- `req` is level-sampled. The requester must drop `req` after `ack`, otherwise a repeated request with equal `req_sel` produces repeated `ack` pulses.

## Timing
- Enable latency: `en` rises in cycle t → `sel_valid`=1 from t+1.
- Auto mode with `dwell`=D≥1: `sel_valid` is high for D cycles, then low for 1 cycle. The channel period is D+1 and a full D0/D1 cycle is 2(D+1).
- Request latency for a differing select: `req` sampled at edge t → GAP in cycle t+1 → new `sel`, `sel_valid`=1 and `ack`=1 in cycle t+2.
- Request latency for an equal select: `ack` in cycle t+1, no gap.
- `sel` never changes in a cycle where `sel_valid`=1.
- `ack` is never high for two consecutive cycles from a single switch.
- Reset asserted in GAP: the switch is aborted, `sel`=0 and `toggles` is not incremented.

## Test plan
- Reset and enable: assert `reset` mid-run → all outputs 0 immediately, without a clock edge. Release `reset`, set `en`=1 → `sel_valid`=1 after one cycle with `sel`=0.
- Auto alternation with `dwell`=3, `auto`=1 for 16 cycles → `sel` sequence 0,0,0,(gap),1,1,1,(gap),0…; `sel_valid` low exactly on the gap cycles; `toggles`=4.
- Manual request: `auto`=0, `sel`=0, `req`=1 with `req_sel`=1 → `busy`=1 at t+1, then `sel`=1 with `ack`=1 at t+2. Repeat with `req_sel`=1 → `ack` at t+1, no gap, `toggles` unchanged.
- Disable during GAP: drop `en` in the gap cycle → `sel` still flips, `toggles`+1, state goes to IDLE, `sel_valid`=0. Raising `en` again restores `sel_valid`=1 after one cycle.
- Edge parameters: `dwell`=0 with `auto`=1 → `sel` never changes and `req` gives no `ack`. `dwell`=1 → `sel` alternates every 2 cycles.
- Saturation and reset: run 300 auto switches → `toggles`=255 and holds. Assert `reset` during a GAP → `sel`=0, `toggles`=0.
